// File: rtl/ntt_sdf_sequencer.sv
// Frame sequencer for a radix-2 SDF NTT pipeline: one global timer drives
// per-stage butterfly select and twiddle addresses, plus output valid/index.
module ntt_sdf_sequencer #(
    parameter int unsigned N         = 8,
    parameter int unsigned STAGE_LAT = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start_i,
    input  logic                              in_valid_i,
    output logic                              in_ready_o,
    output logic                              pipe_en_o,
    output logic [$clog2(N)-1:0]              bf_sel_o,
    output logic [$clog2(N)*$clog2(N/2)-1:0]  tw_addr_o,
    output logic                              out_valid_o,
    output logic [$clog2(N)-1:0]              out_index_o,
    output logic                              busy_o,
    output logic                              done_o
);

    localparam int unsigned STAGES  = $clog2(N);
    localparam int unsigned AW      = $clog2(N / 2);
    localparam int unsigned L_TOTAL = N - 1 + STAGES * STAGE_LAT;
    localparam int unsigned TW      = $clog2(L_TOTAL + N);
    localparam int unsigned IW      = $clog2(N);

    // Cycle at which stage s sees its first sample: upstream FIFO depths plus multiplier latencies.
    function automatic int unsigned stage_off(input int unsigned s);
        int unsigned o;
        o = 0;
        for (int unsigned k = 0; k < s; k++) begin
            o = o + (N >> (k + 1)) + STAGE_LAT;
        end
        return o;
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q;
    logic [TW-1:0] t_q;

    // Timer only advances on pipeline-enabled cycles, so input gaps freeze every control output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            t_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q <= LOAD;
                        t_q     <= '0;
                    end
                end
                LOAD: begin
                    if (in_valid_i) begin
                        t_q <= t_q + TW'(1);
                        if (t_q == TW'(N - 1)) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    t_q <= t_q + TW'(1);
                    if (t_q == TW'(L_TOTAL + N - 1)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    t_q     <= '0;
                end
                default: begin
                    state_q <= IDLE;
                    t_q     <= '0;
                end
            endcase
        end
    end

    logic running;
    assign running    = (state_q == LOAD) || (state_q == DRAIN);
    assign in_ready_o = (state_q == LOAD);
    assign pipe_en_o  = ((state_q == LOAD) && in_valid_i) || (state_q == DRAIN);
    assign busy_o     = (state_q != IDLE);
    assign done_o     = (state_q == DONE);

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int unsigned OFF = stage_off(s);
        localparam int unsigned D   = N >> (s + 1);
        localparam int unsigned DB  = $clog2(D);

        logic [TW-1:0] c;
        logic          act;
        logic          bf;

        assign c   = t_q - TW'(OFF);
        assign act = running && (t_q >= TW'(OFF)) && (c < TW'(N));
        assign bf  = act && c[DB];
        assign bf_sel_o[s] = bf;

        // (c mod D) << s is exactly DB+s == AW bits wide.
        if (DB > 0) begin : g_tw
            logic [AW-1:0] addr;
            if (s > 0) begin : g_shift
                assign addr = {c[DB-1:0], {s{1'b0}}};
            end else begin : g_noshift
                assign addr = c[DB-1:0];
            end
            assign tw_addr_o[s*AW +: AW] = bf ? addr : '0;
        end else begin : g_tw_zero
            assign tw_addr_o[s*AW +: AW] = '0;
        end
    end

    logic [TW-1:0] oi;
    assign oi          = t_q - TW'(L_TOTAL);
    assign out_valid_o = pipe_en_o && (t_q >= TW'(L_TOTAL)) && (oi < TW'(N));
    assign out_index_o = out_valid_o ? IW'(oi) : '0;

endmodule

// File: tb/tb_ntt_sdf_sequencer.sv
// Directed bench: N=8/STAGE_LAT=1 trace table plus an N=16/STAGE_LAT=0 instance.
module tb_ntt_sdf_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start, in_valid;
    logic        in_ready, pipe_en, out_valid, busy, done;
    logic [2:0]  bf_sel, out_index;
    logic [5:0]  tw_addr;

    logic        start_b, in_valid_b;
    logic        in_ready_b, pipe_en_b, out_valid_b, busy_b, done_b;
    logic [3:0]  bf_sel_b, out_index_b;
    logic [11:0] tw_addr_b;

    ntt_sdf_sequencer #(.N(8), .STAGE_LAT(1)) dut (
        .clk(clk), .rst(rst), .start_i(start), .in_valid_i(in_valid),
        .in_ready_o(in_ready), .pipe_en_o(pipe_en), .bf_sel_o(bf_sel),
        .tw_addr_o(tw_addr), .out_valid_o(out_valid), .out_index_o(out_index),
        .busy_o(busy), .done_o(done)
    );

    ntt_sdf_sequencer #(.N(16), .STAGE_LAT(0)) dut_b (
        .clk(clk), .rst(rst), .start_i(start_b), .in_valid_i(in_valid_b),
        .in_ready_o(in_ready_b), .pipe_en_o(pipe_en_b), .bf_sel_o(bf_sel_b),
        .tw_addr_o(tw_addr_b), .out_valid_o(out_valid_b), .out_index_o(out_index_b),
        .busy_o(busy_b), .done_o(done_b)
    );

    typedef struct packed {
        logic       iv;
        logic       rdy;
        logic [2:0] bf;
        logic [5:0] tw;
        logic       ov;
        logic [2:0] oi;
    } vec_t;

    vec_t vec [18];
    int checks   = 0;
    int failures = 0;

    function automatic logic [16:0] mk(input logic rdy, input logic pe, input logic bsy,
                                       input logic dn, input logic [2:0] bf,
                                       input logic [5:0] tw, input logic ov,
                                       input logic [2:0] oi);
        return {rdy, pe, bsy, dn, bf, tw, ov, oi};
    endfunction

    function automatic logic [16:0] obs();
        return {in_ready, pipe_en, busy, done, bf_sel, tw_addr, out_valid, out_index};
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%h expected=%h", name, idx, act, exp);
        end
    endtask

    // Drive inputs on the falling edge, sample 1 time unit later.
    task automatic step(input logic st, input logic iv, input string name, input int idx,
                        input logic [16:0] exp);
        @(negedge clk);
        start    = st;
        in_valid = iv;
        #1;
        check(name, idx, 32'(obs()), 32'(exp));
    endtask

    task automatic run_frame(input string name, input int stall_at, input bit poke,
                             input int abort_at);
        step(1'b1, 1'b0, {name, "_start"}, 0, 17'd0);
        for (int i = 0; i < 18; i++) begin
            if (i == abort_at) return;
            if (i == stall_at) begin
                for (int j = 0; j < 3; j++) begin
                    step(1'b0, 1'b0, {name, "_stall"}, j,
                         mk(1'b1, 1'b0, 1'b1, 1'b0, vec[i].bf, vec[i].tw, 1'b0, 3'd0));
                end
            end
            step(poke && (i == 3 || i == 12), vec[i].iv, name, i,
                 mk(vec[i].rdy, 1'b1, 1'b1, 1'b0, vec[i].bf, vec[i].tw, vec[i].ov, vec[i].oi));
        end
        step(1'b0, 1'b0, {name, "_done"}, 18, mk(1'b0, 1'b0, 1'b1, 1'b1, 3'b0, 6'h0, 1'b0, 3'd0));
    endtask

    initial begin
        //            iv    rdy   bf      tw     ov    oi
        vec[ 0] = '{1'b1, 1'b1, 3'b000, 6'h00, 1'b0, 3'd0};
        vec[ 1] = '{1'b1, 1'b1, 3'b000, 6'h00, 1'b0, 3'd0};
        vec[ 2] = '{1'b1, 1'b1, 3'b000, 6'h00, 1'b0, 3'd0};
        vec[ 3] = '{1'b1, 1'b1, 3'b000, 6'h00, 1'b0, 3'd0};
        vec[ 4] = '{1'b1, 1'b1, 3'b001, 6'h00, 1'b0, 3'd0};
        vec[ 5] = '{1'b1, 1'b1, 3'b001, 6'h01, 1'b0, 3'd0};
        vec[ 6] = '{1'b1, 1'b1, 3'b001, 6'h02, 1'b0, 3'd0};
        vec[ 7] = '{1'b1, 1'b1, 3'b011, 6'h03, 1'b0, 3'd0};
        vec[ 8] = '{1'b0, 1'b0, 3'b010, 6'h08, 1'b0, 3'd0};
        vec[ 9] = '{1'b0, 1'b0, 3'b100, 6'h00, 1'b0, 3'd0};
        vec[10] = '{1'b0, 1'b0, 3'b000, 6'h00, 1'b1, 3'd0};
        vec[11] = '{1'b0, 1'b0, 3'b110, 6'h00, 1'b1, 3'd1};
        vec[12] = '{1'b0, 1'b0, 3'b010, 6'h08, 1'b1, 3'd2};
        vec[13] = '{1'b0, 1'b0, 3'b100, 6'h00, 1'b1, 3'd3};
        vec[14] = '{1'b0, 1'b0, 3'b000, 6'h00, 1'b1, 3'd4};
        vec[15] = '{1'b0, 1'b0, 3'b100, 6'h00, 1'b1, 3'd5};
        vec[16] = '{1'b0, 1'b0, 3'b000, 6'h00, 1'b1, 3'd6};
        vec[17] = '{1'b0, 1'b0, 3'b000, 6'h00, 1'b1, 3'd7};

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; start_b = 1'b0; in_valid_b = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_state", 0, 32'(obs()), 32'd0);
        check("reset_state_b", 0, 32'({busy_b, pipe_en_b, out_valid_b, done_b}), 32'd0);

        run_frame("nominal", -1, 1'b0, -1);
        run_frame("b2b", -1, 1'b0, -1);
        step(1'b0, 1'b0, "idle_after", 0, 17'd0);
        run_frame("stall", 5, 1'b0, -1);
        run_frame("poke", -1, 1'b1, -1);
        step(1'b0, 1'b0, "idle_after_poke", 0, 17'd0);

        // Abort mid-drain at t=12, then a clean frame.
        run_frame("abort", -1, 1'b0, 12);
        @(negedge clk);
        rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("after_reset", 0, 32'(obs()), 32'd0);
        run_frame("post_reset", -1, 1'b0, -1);

        // N=16, STAGE_LAT=0: output starts at t=15 inside LOAD.
        begin
            int nvalid;
            nvalid = 0;
            @(negedge clk);
            start_b = 1'b1;
            for (int k = 0; k < 33; k++) begin
                logic [7:0] exp_b;
                @(negedge clk);
                start_b    = 1'b0;
                in_valid_b = (k < 16);
                #1;
                exp_b = {(k < 16) ? 1'b1 : 1'b0,
                         (k >= 15 && k <= 30) ? 1'b1 : 1'b0,
                         (k >= 15 && k <= 30) ? 4'(k - 15) : 4'd0,
                         (k >= 8 && k <= 15) ? 1'b1 : 1'b0,
                         (k == 31) ? 1'b1 : 1'b0};
                check("n16", k,
                      32'({in_ready_b, out_valid_b, out_index_b, bf_sel_b[0], done_b}),
                      32'(exp_b));
                if (out_valid_b) nvalid++;
            end
            check("n16_count", 0, 32'(nvalid), 32'd16);
            check("n16_idle", 0, 32'({busy_b, pipe_en_b}), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ntt_sdf_sequencer.md
Name: ntt_sdf_sequencer

Overview:
- Central controller for a multi-stage radix-2 single-path-delay-feedback (SDF) NTT pipeline.
- Each stage is the butterfly / feedback-FIFO / mux / Montgomery-multiplier datapath already used in the design.
- Accepts one N-point frame per start, advances a global pipeline timer, and drives per-stage controls: butterfly select and twiddle-RAM read address.
- Generates a global pipeline enable, output-valid/index and a done pulse.

Parameters:
- N, 8: transform length; power of 2, >= 4.
- STAGE_LAT, 1: register latency of one stage's multiplier path, in cycles.
- STAGES, $clog2(N): localparam, number of stages.
- AW, $clog2(N/2): localparam, twiddle address width per stage.
- L_TOTAL, N-1+STAGES*STAGE_LAT: localparam, first-in to first-out latency.
- TW, $clog2(L_TOTAL+N): localparam, timer width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a frame; sampled only in IDLE.
- in_valid  in  1  input sample present this cycle.
- in_ready  out  1  controller accepts samples (LOAD state).
- pipe_en  out  1  global enable for all stage registers, FIFOs and multipliers.
- bf_sel  out  STAGES  per-stage select: 1 = butterfly/pop phase, 0 = fill/bypass phase.
- tw_addr  out  STAGES*AW  per-stage twiddle read address; stage s occupies bits [s*AW +: AW].
- out_valid  out  1  final-stage output word valid.
- out_index  out  $clog2(N)  natural-order index of the output word.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when the frame has fully drained.

Behaviour:
- FSM states: IDLE, LOAD, DRAIN, DONE.
- Reset (any state, including mid-frame): state=IDLE, t=0. All outputs 0.
- IDLE:
  - start=1 -> LOAD, t=0.
  - start in any other state is ignored.
- LOAD:
  - in_ready=1; accept = in_valid.
  - pipe_en = in_valid. t increments only on cycles where pipe_en=1.
  - Gaps in in_valid stall the entire pipeline; all outputs hold their values.
  - Accepting the sample at t==N-1 -> DRAIN.
- DRAIN:
  - in_ready=0, pipe_en=1, t increments every cycle.
  - At t==L_TOTAL+N-1 -> DONE.
- DONE: done=1 for exactly one cycle, pipe_en=0, then -> IDLE.
- Stage timing, delay D_s = N>>(s+1):
  - Offset O_0 = 0; O_s = sum over k<s of (D_k + STAGE_LAT).
  - Local count c_s = t - O_s.
  - Stage active when O_s <= t < O_s+N.
- bf_sel[s] = active_s AND bit log2(D_s) of c_s. The first D_s samples fill the FIFO, the next D_s run the butterfly, repeating.
- tw_addr[s] = (c_s mod D_s) << s while bf_sel[s]=1; 0 otherwise. Width is AW, truncated.
- out_valid = pipe_en AND (L_TOTAL <= t <= L_TOTAL+N-1).
  - Output may begin during LOAD when STAGE_LAT=0.
- out_index = t - L_TOTAL while out_valid; 0 otherwise. Bit-reversal is performed downstream.
- All control outputs are combinational from state and t (same cycle as pipe_en). The datapath registers them on pipe_en.
- Arithmetic: t is unsigned TW bits and never wraps within a frame. Offsets are computed at elaboration time.

Test Plan:
- Nominal frame, N=8, STAGE_LAT=1, start then 8 consecutive in_valid:
  - bf_sel[0] high at t=4..7, with tw_addr[0] = 0,1,2,3.
  - bf_sel[1] high at t=7,8,11,12, with tw_addr[1] = 0,2,0,2.
  - bf_sel[2] high at t=9,11,13,15, with tw_addr[2] = 0.
  - out_valid at t=10..17 with out_index 0..7; done pulses on the next cycle; busy then drops.
- Input stall: in_valid low for 3 cycles after the 5th sample.
  - pipe_en=0 and t, bf_sel, tw_addr held for those 3 cycles.
  - Resumed sequence is identical to nominal, shifted by 3 cycles.
- Start while busy: pulse start during LOAD and during DRAIN.
  - No restart; t is unaffected; exactly one done pulse.
- Reset mid-DRAIN (t=12):
  - Next cycle busy=0, all outputs 0.
  - A new start runs a clean nominal frame.
- STAGE_LAT=0, N=16:
  - out_valid first asserts at t=15 while still in LOAD.
  - 16 outputs; done one cycle after t=30.
- Back-to-back frames: start asserted in the cycle after done.
  - Second frame control trace matches the first exactly.
